data_memory_arbiter: RTL and testbench

Shares the single data-memory port (the `memoryDatabase` instance behind the MEM stage) between two requesters: the pipeline MEM stage (CPU port) and an external I/O master (loader/debug/display port). The CPU has priority and sees the memory combinationally with zero added latency. The I/O master uses a req/ack handshake and is protected from starvation by a wait counter. The block sits between the MEM stage and the data memory and stalls the pipeline only when an I/O access is forced.

---
 rtl/data_memory_arbiter_if.sv | 37 +++
 rtl/data_memory_arbiter.sv | 50 +++++
 tb/tb_data_memory_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_if.sv
// data_memory_arbiter_if: CPU, I/O and data-memory buses around the arbiter
interface data_memory_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  cpuReq;
   logic                  cpuWrite;
   logic [ADDR_WIDTH-1:0] cpuAddress;
   logic [DATA_WIDTH-1:0] cpuWriteData;
   logic [DATA_WIDTH-1:0] cpuReadData;
   logic                  cpuStall;
   logic                  ioReq;
   logic                  ioWrite;
   logic [ADDR_WIDTH-1:0] ioAddress;
   logic [DATA_WIDTH-1:0] ioWriteData;
   logic [DATA_WIDTH-1:0] ioReadData;
   logic                  ioAck;
   logic                  memWrite;
   logic [ADDR_WIDTH-1:0] memAddress;
   logic [DATA_WIDTH-1:0] memWriteData;
   logic [DATA_WIDTH-1:0] memReadData;
   logic                  grantIo;
   modport slave (
      input  cpuReq, cpuWrite, cpuAddress, cpuWriteData,
      input  ioReq, ioWrite, ioAddress, ioWriteData,
      input  memReadData,
      output cpuReadData, cpuStall, ioReadData, ioAck,
      output memWrite, memAddress, memWriteData, grantIo
   );
   modport master (
      output cpuReq, cpuWrite, cpuAddress, cpuWriteData,
      output ioReq, ioWrite, ioAddress, ioWriteData,
      output memReadData,
      input  cpuReadData, cpuStall, ioReadData, ioAck,
      input  memWrite, memAddress, memWriteData, grantIo
   );
endinterface

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares the data-memory port between the MEM stage and an I/O master
module data_memory_arbiter #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int IO_STARVE_LIMIT = 4
) (
   input logic                  clk,
   input logic                  reset,
   data_memory_arbiter_if.slave bus
);
   localparam int CW = $clog2(IO_STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(IO_STARVE_LIMIT);
   typedef enum logic {IDLE, IO_ACK} state_t;
   state_t                state, next_state;
   logic [CW-1:0]         waitCnt;
   logic [DATA_WIDTH-1:0] ioReadData;
   logic [ADDR_WIDTH-1:0] memAddress;
   logic                  grantIo, grantCpu, ackPending;
   assign ackPending = state == IO_ACK;
   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= next_state;
   // every I/O grant is followed by exactly one ack cycle
   always_comb next_state = (state == IDLE && grantIo) ? IO_ACK : IDLE;
   // CPU wins unless the I/O request has waited out its starvation budget
   always_comb begin
      grantIo           = bus.ioReq & ~ackPending & (~bus.cpuReq | waitCnt == LIMIT);
      grantCpu          = bus.cpuReq & ~grantIo;
      memAddress        = grantIo ? bus.ioAddress : bus.cpuAddress;
      bus.grantIo       = grantIo;
      bus.cpuStall      = bus.cpuReq & ~grantCpu;
      bus.memWrite      = grantIo ? bus.ioWrite : grantCpu & bus.cpuWrite;
      bus.memAddress    = memAddress;
      bus.memWriteData  = grantIo ? bus.ioWriteData : bus.cpuWriteData;
      bus.cpuReadData   = bus.memReadData;
      bus.ioAck         = ackPending;
      bus.ioReadData    = ioReadData;
   end
   // starvation counter and I/O read-data capture (old contents are captured on writes too)
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         waitCnt    <= '0;
         ioReadData <= '0;
      end else begin
         waitCnt    <= (grantIo | ~bus.ioReq) ? '0 :
                       (ackPending | waitCnt == LIMIT) ? waitCnt : waitCnt + 1'b1;
         if (grantIo) ioReadData <= bus.memReadData;
      end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: table vectors, reset corner case and random traffic vs a reference model
module tb_data_memory_arbiter;
   localparam int LIMIT = 4;
   typedef struct {
      logic        cr, cw;
      logic [31:0] ca, cd;
      logic        ir, iw;
      logic [31:0] ia, id;
      logic        e_gio, e_stall, e_ack;
      logic [31:0] e_rd, e_iord;
   } vec_t;
   logic        clk = 0;
   logic        reset_n = 0;
   logic [31:0] mem [256];
   logic [31:0] ref_mem [256];
   logic        m_ack = 0;
   int          m_wait = 0;
   logic [31:0] m_iord = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   vec_t        tbl[$];
   data_memory_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
   data_memory_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .IO_STARVE_LIMIT(LIMIT)) dut (
      .clk(clk),
      .reset(reset_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   assign bus.memReadData = mem[bus.memAddress[9:2]];
   always @(posedge clk) if (bus.memWrite) mem[bus.memAddress[9:2]] <= bus.memWriteData;
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask
   function automatic vec_t v(logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
                              logic ir, logic iw, logic [31:0] ia, logic [31:0] id,
                              logic e_gio, logic e_stall, logic e_ack,
                              logic [31:0] e_rd, logic [31:0] e_iord);
      vec_t r;
      r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
      r.ir = ir; r.iw = iw; r.ia = ia; r.id = id;
      r.e_gio = e_gio; r.e_stall = e_stall; r.e_ack = e_ack;
      r.e_rd = e_rd; r.e_iord = e_iord;
      return r;
   endfunction
   // one clock cycle: check every output against the model, then advance the model
   task automatic step();
      logic gio, gcpu, ew;
      logic [31:0] ea;
      #2;
      gio  = bus.ioReq && !m_ack && (!bus.cpuReq || m_wait >= LIMIT);
      gcpu = bus.cpuReq && !gio;
      ew   = gio ? bus.ioWrite : (gcpu && bus.cpuWrite);
      ea   = gio ? bus.ioAddress : bus.cpuAddress;
      chk("grantIo", 64'(bus.grantIo), 64'(gio));
      chk("cpuStall", 64'(bus.cpuStall), 64'(bus.cpuReq && !gcpu));
      chk("memWrite", 64'(bus.memWrite), 64'(ew));
      chk("memAddress", 64'(bus.memAddress), 64'(ea));
      if (ew) chk("memWriteData", 64'(bus.memWriteData), 64'(gio ? bus.ioWriteData : bus.cpuWriteData));
      if (gcpu && !bus.cpuWrite) chk("cpuReadData", 64'(bus.cpuReadData), 64'(ref_mem[ea[9:2]]));
      chk("ioAck", 64'(bus.ioAck), 64'(m_ack));
      chk("ioReadData", 64'(bus.ioReadData), 64'(m_iord));
      chk("waitCnt", 64'(dut.waitCnt), 64'(m_wait));
      @(posedge clk);
      if (gio) m_iord = ref_mem[ea[9:2]];
      if (ew) ref_mem[ea[9:2]] = gio ? bus.ioWriteData : bus.cpuWriteData;
      m_wait = (gio || !bus.ioReq) ? 0 : (!m_ack && m_wait < LIMIT) ? m_wait + 1 : m_wait;
      m_ack = gio;
      @(negedge clk);
   endtask
   task automatic apply(input vec_t t);
      bus.cpuReq = t.cr; bus.cpuWrite = t.cw; bus.cpuAddress = t.ca; bus.cpuWriteData = t.cd;
      bus.ioReq = t.ir; bus.ioWrite = t.iw; bus.ioAddress = t.ia; bus.ioWriteData = t.id;
   endtask
   initial begin
      vec_t idle, cs, rd;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 0;
         ref_mem[i] = 0;
      end
      idle = v(0,0,0,0, 0,0,0,0, 0,0,0, 0,0);
      apply(idle);
      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_ioAck", 64'(bus.ioAck), 0);
      chk("rst_ioReadData", 64'(bus.ioReadData), 0);
      chk("rst_grantIo", 64'(bus.grantIo), 0);
      chk("rst_memWrite", 64'(bus.memWrite), 0);
      chk("rst_cpuStall", 64'(bus.cpuStall), 0);
      reset_n = 1;
      // CPU only
      tbl.push_back(v(1,1,32'h40,32'hDEADBEEF, 0,0,0,0, 0,0,0, 0,0));
      tbl.push_back(v(1,0,32'h40,0, 0,0,0,0, 0,0,0, 32'hDEADBEEF,0));
      // I/O only
      tbl.push_back(v(0,0,0,0, 1,0,32'h40,0, 1,0,0, 0,0));
      tbl.push_back(v(0,0,0,0, 0,0,0,0, 0,0,1, 0,32'hDEADBEEF));
      tbl.push_back(idle);
      // starvation: busy CPU, I/O write forced through on the fifth cycle
      cs = v(1,0,32'h40,0, 1,1,32'h44,32'h12345678, 0,0,0, 32'hDEADBEEF,0);
      for (int i = 0; i < 4; i++) tbl.push_back(cs);
      cs.e_gio = 1; cs.e_stall = 1;
      tbl.push_back(cs);
      tbl.push_back(v(1,0,32'h40,0, 0,0,0,0, 0,0,1, 32'hDEADBEEF,0));
      tbl.push_back(idle);
      // back-to-back I/O writes with ioReq held
      tbl.push_back(v(0,0,0,0, 1,1,32'h100,32'hA1, 1,0,0, 0,0));
      tbl.push_back(v(0,0,0,0, 1,1,32'h104,32'hA2, 0,0,1, 0,0));
      tbl.push_back(v(0,0,0,0, 1,1,32'h104,32'hA2, 1,0,0, 0,0));
      tbl.push_back(v(0,0,0,0, 1,1,32'h108,32'hA3, 0,0,1, 0,0));
      tbl.push_back(v(0,0,0,0, 1,1,32'h108,32'hA3, 1,0,0, 0,0));
      tbl.push_back(v(0,0,0,0, 0,0,0,0, 0,0,1, 0,0));
      tbl.push_back(v(1,0,32'h100,0, 0,0,0,0, 0,0,0, 32'hA1,0));
      tbl.push_back(v(1,0,32'h104,0, 0,0,0,0, 0,0,0, 32'hA2,0));
      tbl.push_back(v(1,0,32'h108,0, 0,0,0,0, 0,0,0, 32'hA3,0));
      tbl.push_back(v(1,0,32'h44,0, 0,0,0,0, 0,0,0, 32'h12345678,0));
      // simultaneous contention from idle
      tbl.push_back(v(1,0,32'h40,0, 1,0,32'h40,0, 0,0,0, 32'hDEADBEEF,0));
      tbl.push_back(v(0,0,0,0, 1,0,32'h40,0, 1,0,0, 0,0));
      tbl.push_back(v(0,0,0,0, 0,0,0,0, 0,0,1, 0,32'hDEADBEEF));
      foreach (tbl[i]) begin
         apply(tbl[i]);
         #1;
         chk($sformatf("vec%0d_grantIo", i), 64'(bus.grantIo), 64'(tbl[i].e_gio));
         chk($sformatf("vec%0d_cpuStall", i), 64'(bus.cpuStall), 64'(tbl[i].e_stall));
         chk($sformatf("vec%0d_ioAck", i), 64'(bus.ioAck), 64'(tbl[i].e_ack));
         if (tbl[i].cr && !tbl[i].cw && !tbl[i].e_stall)
            chk($sformatf("vec%0d_cpuReadData", i), 64'(bus.cpuReadData), 64'(tbl[i].e_rd));
         if (tbl[i].e_ack)
            chk($sformatf("vec%0d_ioReadData", i), 64'(bus.ioReadData), 64'(tbl[i].e_iord));
         step();
      end
      // reset asserted in the ack cycle drops the ack at once
      rd = v(0,0,0,0, 1,0,32'h40,0, 0,0,0, 0,0);
      apply(rd);
      step();
      apply(idle);
      reset_n = 0;
      #1;
      chk("rstack_ioAck", 64'(bus.ioAck), 0);
      chk("rstack_ioReadData", 64'(bus.ioReadData), 0);
      chk("rstack_waitCnt", 64'(dut.waitCnt), 0);
      chk("rstack_grantIo", 64'(bus.grantIo), 0);
      chk("rstack_memWrite", 64'(bus.memWrite), 0);
      m_ack = 0;
      m_wait = 0;
      m_iord = 0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1;
      step();
      // random traffic; the I/O master holds its request until it has been acknowledged
      for (int c = 0; c < 400; c++) begin
         bus.cpuReq = $urandom_range(0, 3) != 0;
         bus.cpuWrite = $urandom_range(0, 1) == 1;
         bus.cpuAddress = 32'($urandom_range(0, 15)) << 2;
         bus.cpuWriteData = $urandom;
         if (!bus.ioReq || m_ack) begin
            bus.ioReq = $urandom_range(0, 2) != 0;
            bus.ioWrite = $urandom_range(0, 1) == 1;
            bus.ioAddress = 32'($urandom_range(0, 15)) << 2;
            bus.ioWriteData = $urandom;
         end
         step();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
